dense_layer: RTL

Fully-connected (dense) classifier stage placed directly downstream of the global average pooling stage. It collects NUM_INPUTS pooled features from the pooling output stream, then computes NUM_OUTPUTS neurons one at a time with a single time-multiplexed MAC. Weights come from an external synchronous weight ROM. Results are emitted as a ReLU-clipped stream of class scores for a downstream argmax/host.

---
 rtl/dense_layer_pkg.sv | 28 ++
 rtl/dense_layer_if.sv | 43 ++++
 rtl/dense_layer_mac.sv | 34 +++
 rtl/dense_layer.sv | 133 +++++++++++++
 4 files changed

// File: rtl/dense_layer_pkg.sv
// Shared types and helpers for the dense classifier stage.
package dense_layer_pkg;

  typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} dense_state_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  // Clamp a signed value into [0, 2^width-1].
  function automatic logic [31:0] sat_relu(input logic signed [63:0] acc,
                                           input int unsigned width);
    logic signed [63:0] max_v;
    max_v = (64'sd1 <<< width) - 64'sd1;
    if (acc < 0) return '0;
    if (acc > max_v) return max_v[31:0];
    return acc[31:0];
  endfunction

endpackage

// File: rtl/dense_layer_if.sv
// Feature input stream, weight ROM port and score output stream of the dense stage.
interface dense_layer_if #(
  parameter int unsigned DATA_WIDTH   = 12,
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH   = 5
);
  logic                           dense_ready_in;
  logic                           dense_valid_in;
  logic        [DATA_WIDTH-1:0]   dense_data_in;
  logic                           wt_rd_en;
  logic        [ADDR_WIDTH-1:0]   wt_addr;
  logic signed [WEIGHT_WIDTH-1:0] wt_data;
  logic                           dense_ready_out;
  logic                           dense_valid_out;
  logic        [DATA_WIDTH-1:0]   dense_data_out;
  logic                           dense_last_out;

  modport slave (
    output dense_ready_in,
    input  dense_valid_in,
    input  dense_data_in,
    output wt_rd_en,
    output wt_addr,
    input  wt_data,
    input  dense_ready_out,
    output dense_valid_out,
    output dense_data_out,
    output dense_last_out
  );

  modport master (
    input  dense_ready_in,
    output dense_valid_in,
    output dense_data_in,
    input  wt_rd_en,
    input  wt_addr,
    output wt_data,
    output dense_ready_out,
    input  dense_valid_out,
    input  dense_data_out,
    input  dense_last_out
  );
endinterface

// File: rtl/dense_layer_mac.sv
// Registered signed MAC: unsigned feature times signed weight, with clear-on-first-term.
module dense_mac #(
  parameter int unsigned DATA_WIDTH   = 12,
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned ACC_WIDTH    = 24
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr_i,
  input  logic                           en_i,
  input  logic        [DATA_WIDTH-1:0]   x_i,
  input  logic signed [WEIGHT_WIDTH-1:0] w_i,
  output logic signed [ACC_WIDTH-1:0]    sum_o
);
  localparam int unsigned ProdW = DATA_WIDTH + WEIGHT_WIDTH + 1;

  logic signed [ProdW-1:0]     x_ext, w_ext, prod;
  logic signed [ACC_WIDTH-1:0] acc_q, base;

  assign x_ext = ProdW'($signed({1'b0, x_i}));
  assign w_ext = ProdW'(w_i);
  assign prod  = x_ext * w_ext;
  assign base  = clr_i ? '0 : acc_q;
  // Sum is exposed combinationally so the final term can be captured in the same edge.
  assign sum_o = base + ACC_WIDTH'(prod);

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= sum_o;
    end
  end
endmodule

// File: rtl/dense_layer.sv
// Dense layer: buffers NUM_INPUTS features, then computes each neuron with one shared MAC.
module dense_layer
  import dense_layer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 12,
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned NUM_INPUTS   = 8,
  parameter int unsigned NUM_OUTPUTS  = 4,
  parameter int unsigned FRAC_BITS    = 4
) (
  input  logic         clk,
  input  logic         rst,
  dense_layer_if.slave bus_io
);
  localparam int unsigned AccW  = DATA_WIDTH + WEIGHT_WIDTH + 1 + clog2(NUM_INPUTS);
  localparam int unsigned AddrW = (clog2(NUM_INPUTS * NUM_OUTPUTS) > 0) ?
                                  clog2(NUM_INPUTS * NUM_OUTPUTS) : 1;
  localparam int unsigned IdxW  = (clog2(NUM_INPUTS) > 0) ? clog2(NUM_INPUTS) : 1;
  localparam int unsigned NeuW  = (clog2(NUM_OUTPUTS) > 0) ? clog2(NUM_OUTPUTS) : 1;
  localparam int unsigned CntW  = clog2(NUM_INPUTS + 1);

  dense_state_t          state_q, state_d;
  logic [IdxW-1:0]       in_cnt_q, in_cnt_d;
  logic [CntW-1:0]       iss_q, iss_d;
  logic [NeuW-1:0]       neu_q, neu_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [IdxW-1:0]       rd_idx_q;
  logic                  rd_vld_q;
  logic                  rdy_q;
  logic [DATA_WIDTH-1:0] feat_q [NUM_INPUTS];

  logic                  in_hs, out_hs, issue, last_ret;
  logic signed [AccW-1:0] sum, shifted;
  logic [DATA_WIDTH-1:0] clipped;

  assign in_hs    = rdy_q & bus_io.dense_valid_in;
  assign out_hs   = (state_q == OUTPUT) & bus_io.dense_ready_out;
  assign issue    = (state_q == COMPUTE) && (iss_q < CntW'(NUM_INPUTS));
  assign last_ret = rd_vld_q && (rd_idx_q == IdxW'(NUM_INPUTS - 1));

  dense_mac #(
    .DATA_WIDTH  (DATA_WIDTH),
    .WEIGHT_WIDTH(WEIGHT_WIDTH),
    .ACC_WIDTH   (AccW)
  ) u_mac (
    .clk  (clk),
    .rst  (rst),
    .clr_i(rd_idx_q == '0),
    .en_i (rd_vld_q),
    .x_i  (feat_q[rd_idx_q]),
    .w_i  (bus_io.wt_data),
    .sum_o(sum)
  );

  assign shifted = sum >>> FRAC_BITS;
  assign clipped = DATA_WIDTH'(sat_relu(64'(shifted), DATA_WIDTH));

  always_comb begin
    state_d  = state_q;
    in_cnt_d = in_cnt_q;
    iss_d    = iss_q;
    neu_d    = neu_q;
    data_d   = data_q;
    unique case (state_q)
      LOAD: begin
        if (in_hs) begin
          if (in_cnt_q == IdxW'(NUM_INPUTS - 1)) begin
            in_cnt_d = '0;
            neu_d    = '0;
            iss_d    = '0;
            state_d  = COMPUTE;
          end else begin
            in_cnt_d = in_cnt_q + IdxW'(1);
          end
        end
      end
      COMPUTE: begin
        if (issue) iss_d = iss_q + CntW'(1);
        if (last_ret) begin
          data_d  = clipped;
          iss_d   = '0;
          state_d = OUTPUT;
        end
      end
      OUTPUT: begin
        if (out_hs) begin
          if (neu_q == NeuW'(NUM_OUTPUTS - 1)) begin
            neu_d   = '0;
            state_d = LOAD;
          end else begin
            neu_d   = neu_q + NeuW'(1);
            state_d = COMPUTE;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= LOAD;
      in_cnt_q <= '0;
      iss_q    <= '0;
      neu_q    <= '0;
      data_q   <= '0;
      rd_vld_q <= 1'b0;
      rd_idx_q <= '0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_cnt_q <= in_cnt_d;
      iss_q    <= iss_d;
      neu_q    <= neu_d;
      data_q   <= data_d;
      // ROM answers one cycle after the read, so tag the returning word with its feature index.
      rd_vld_q <= issue;
      rd_idx_q <= IdxW'(iss_q);
      rdy_q    <= (state_d == LOAD);
    end
  end

  always_ff @(posedge clk) begin
    if (in_hs) feat_q[in_cnt_q] <= bus_io.dense_data_in;
  end

  assign bus_io.dense_ready_in  = rdy_q;
  assign bus_io.wt_rd_en        = issue;
  assign bus_io.wt_addr         = AddrW'(int'(neu_q) * int'(NUM_INPUTS) + int'(iss_q));
  assign bus_io.dense_valid_out = (state_q == OUTPUT);
  assign bus_io.dense_data_out  = data_q;
  assign bus_io.dense_last_out  = (state_q == OUTPUT) && (neu_q == NeuW'(NUM_OUTPUTS - 1));
endmodule
